// File: rtl/alu_mem_sequencer.sv
// ---------------------------------------------------------------------------
// alu_mem_sequencer
//   Command-driven controller that owns the single port of a 512x8 synchronous
//   memory (MEM) and feeds a combinational 8-bit ALU (alu8bit). For every
//   accepted command it reads operand A, then operand B, lets the ALU evaluate,
//   writes the result back to MEM and pulses done.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   cmd_valid / cmd_ready : command handshake (accept on valid && ready)
//   cmd_op, cmd_addr_a/b/z: ALU opcode and MEM addresses, latched on accept
//   done, result, op_count: completion pulse, last ALU result, saturating count
//   mem_*                 : MEM address / data_in / WE / RE / Enable, data_out
//   alu_*                 : ALU operands and ctrl, aluout
//
// Parameters
//   RD_LAT : MEM read latency in cycles after the RE cycle (1..3)
//   CNT_W  : width of the completed-command counter
// ---------------------------------------------------------------------------
module alu_mem_sequencer #(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [8:0]       cmd_addr_a,
  input  logic [8:0]       cmd_addr_b,
  input  logic [8:0]       cmd_addr_z,
  output logic             done,
  output logic [7:0]       result,
  output logic [CNT_W-1:0] op_count,
  output logic [8:0]       mem_address,
  output logic [7:0]       mem_data_in,
  output logic             mem_WE,
  output logic             mem_RE,
  output logic             mem_Enable,
  input  logic [7:0]       mem_data_out,
  output logic [7:0]       alu_ain,
  output logic [7:0]       alu_bin,
  output logic [3:0]       alu_ctrl,
  input  logic [7:0]       alu_aluout
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_A   = 3'd1,
    ST_WAIT_A = 3'd2,
    ST_RD_B   = 3'd3,
    ST_WAIT_B = 3'd4,
    ST_EXEC   = 3'd5,
    ST_WR_Z   = 3'd6,
    ST_DONE   = 3'd7
  } state_t;

  // Wait counter value on the cycle whose closing edge samples mem_data_out.
  localparam logic [1:0]       LAST_WAIT = 2'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state_r;
  state_t     nxt_state_s;
  logic [1:0] wait_cnt_r;
  logic [8:0] addr_b_r;
  logic [8:0] addr_z_r;
  logic       wait_last_s;
  logic       accept_s;

  logic       ready_nxt_s;
  logic       done_nxt_s;
  logic       re_nxt_s;
  logic       we_nxt_s;
  logic       en_nxt_s;
  logic [8:0] addr_nxt_s;

  assign wait_last_s = (wait_cnt_r == LAST_WAIT);
  assign accept_s    = (state_r == ST_IDLE) && cmd_valid;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= nxt_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    nxt_state_s = state_r;
    case (state_r)
      ST_IDLE:   if (cmd_valid) nxt_state_s = ST_RD_A;   else nxt_state_s = ST_IDLE;
      ST_RD_A:   nxt_state_s = ST_WAIT_A;
      ST_WAIT_A: if (wait_last_s) nxt_state_s = ST_RD_B; else nxt_state_s = ST_WAIT_A;
      ST_RD_B:   nxt_state_s = ST_WAIT_B;
      ST_WAIT_B: if (wait_last_s) nxt_state_s = ST_EXEC; else nxt_state_s = ST_WAIT_B;
      ST_EXEC:   nxt_state_s = ST_WR_Z;
      ST_WR_Z:   nxt_state_s = ST_DONE;
      ST_DONE:   nxt_state_s = ST_IDLE;
      default:   nxt_state_s = ST_IDLE;
    endcase
  end

  // Output decode: values the control outputs take in the upcoming state, so
  // that they can be registered and still line up with that state.
  always_comb begin
    ready_nxt_s = 1'b0;
    done_nxt_s  = 1'b0;
    re_nxt_s    = 1'b0;
    we_nxt_s    = 1'b0;
    en_nxt_s    = 1'b0;
    addr_nxt_s  = mem_address;
    case (nxt_state_s)
      ST_IDLE:   ready_nxt_s = 1'b1;
      // RD_A is only entered from IDLE, so the address comes straight from the
      // command being accepted on this edge.
      ST_RD_A:   begin re_nxt_s = 1'b1; en_nxt_s = 1'b1; addr_nxt_s = cmd_addr_a; end
      ST_WAIT_A: en_nxt_s = 1'b1;
      ST_RD_B:   begin re_nxt_s = 1'b1; en_nxt_s = 1'b1; addr_nxt_s = addr_b_r; end
      ST_WAIT_B: en_nxt_s = 1'b1;
      ST_EXEC:   en_nxt_s = 1'b0;
      ST_WR_Z:   begin we_nxt_s = 1'b1; en_nxt_s = 1'b1; addr_nxt_s = addr_z_r; end
      ST_DONE:   done_nxt_s = 1'b1;
      default:   ready_nxt_s = 1'b0;
    endcase
  end

  // Registered control outputs and the completed-command counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_ready   <= 1'b1;
      done        <= 1'b0;
      mem_RE      <= 1'b0;
      mem_WE      <= 1'b0;
      mem_Enable  <= 1'b0;
      mem_address <= 9'd0;
      op_count    <= {CNT_W{1'b0}};
    end else begin
      cmd_ready   <= ready_nxt_s;
      done        <= done_nxt_s;
      mem_RE      <= re_nxt_s;
      mem_WE      <= we_nxt_s;
      mem_Enable  <= en_nxt_s;
      mem_address <= addr_nxt_s;
      // Count on entry to DONE so op_count already reflects the command
      // while done is high.
      if ((nxt_state_s == ST_DONE) && (op_count != CNT_MAX)) begin
        op_count <= op_count + CNT_ONE;
      end
    end
  end

  // Command latches, read-wait counter, operand capture and ALU result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_ctrl    <= 4'd0;
      addr_b_r    <= 9'd0;
      addr_z_r    <= 9'd0;
      wait_cnt_r  <= 2'd0;
      alu_ain     <= 8'd0;
      alu_bin     <= 8'd0;
      result      <= 8'd0;
      mem_data_in <= 8'd0;
    end else begin
      if (accept_s) begin
        alu_ctrl <= cmd_op;
        addr_b_r <= cmd_addr_b;
        addr_z_r <= cmd_addr_z;
      end
      if ((state_r == ST_WAIT_A) || (state_r == ST_WAIT_B)) begin
        wait_cnt_r <= wait_last_s ? 2'd0 : (wait_cnt_r + 2'd1);
      end else begin
        wait_cnt_r <= 2'd0;
      end
      if ((state_r == ST_WAIT_A) && wait_last_s) begin
        alu_ain <= mem_data_out;
      end
      if ((state_r == ST_WAIT_B) && wait_last_s) begin
        alu_bin <= mem_data_out;
      end
      // The write data is taken from the ALU directly so it is valid in WR_Z
      // together with the registered result.
      if (state_r == ST_EXEC) begin
        result      <= alu_aluout;
        mem_data_in <= alu_aluout;
      end
    end
  end

endmodule

// File: tb/tb_alu_mem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_mem_sequencer
//   Directed bench for alu_mem_sequencer. Two instances: the default one
//   (RD_LAT=1, CNT_W=16) and a second one (RD_LAT=3, CNT_W=2) for latency and
//   counter saturation. Each instance gets its own behavioural 512x8 MEM and
//   an alu8bit model; expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_mem_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] cmd_op;
  logic [8:0] cmd_addr_a, cmd_addr_b, cmd_addr_z;
  logic       cmd_valid, cmd_valid3;

  logic        cmd_ready, done, mem_WE, mem_RE, mem_Enable;
  logic [7:0]  result, mem_data_in, mem_data_out, alu_ain, alu_bin, alu_aluout;
  logic [15:0] op_count;
  logic [8:0]  mem_address;
  logic [3:0]  alu_ctrl;

  logic        cmd_ready3, done3, mem_WE3, mem_RE3, mem_Enable3;
  logic [7:0]  result3, mem_data_in3, mem_data_out3, alu_ain3, alu_bin3, alu_aluout3;
  logic [1:0]  op_count3;
  logic [8:0]  mem_address3;
  logic [3:0]  alu_ctrl3;

  logic       pre_we, pre_sel;
  logic [8:0] pre_addr;
  logic [7:0] pre_data;

  logic [7:0] mem  [0:511];
  logic [7:0] mem3 [0:511];
  logic [7:0] rd_q;
  logic [7:0] p0, p1, p2;

  int total = 0;
  int bad   = 0;

  // alu8bit model; results for A=8'hA6, B=8'h3B in exp_tbl.
  logic [7:0] exp_tbl [16] = '{8'hE1, 8'h6B, 8'h22, 8'hBF, 8'h9D, 8'h59, 8'h4C, 8'h53,
                               8'hA7, 8'hA5, 8'hA6, 8'h3B, 8'hDD, 8'h40, 8'h62, 8'h95};

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] op);
    case (op)
      4'h0: alu_f = a + b;
      4'h1: alu_f = a - b;
      4'h2: alu_f = a & b;
      4'h3: alu_f = a | b;
      4'h4: alu_f = a ^ b;
      4'h5: alu_f = ~a;
      4'h6: alu_f = {a[6:0], 1'b0};
      4'h7: alu_f = {1'b0, a[7:1]};
      4'h8: alu_f = a + 8'd1;
      4'h9: alu_f = a - 8'd1;
      4'hA: alu_f = a;
      4'hB: alu_f = b;
      4'hC: alu_f = ~(a & b);
      4'hD: alu_f = ~(a | b);
      4'hE: alu_f = ~(a ^ b);
      default: alu_f = b - a;
    endcase
  endfunction

  assign alu_aluout  = alu_f(alu_ain, alu_bin, alu_ctrl);
  assign alu_aluout3 = alu_f(alu_ain3, alu_bin3, alu_ctrl3);

  // MEM model, read latency 1, with a bench back-door for preloading.
  always @(posedge clk) begin
    if (pre_we && !pre_sel) mem[pre_addr] <= pre_data;
    else if (mem_Enable && mem_WE) mem[mem_address] <= mem_data_in;
    if (mem_Enable && mem_RE) rd_q <= mem[mem_address];
  end
  assign mem_data_out = rd_q;

  // MEM model, read latency 3.
  always @(posedge clk) begin
    if (pre_we && pre_sel) mem3[pre_addr] <= pre_data;
    else if (mem_Enable3 && mem_WE3) mem3[mem_address3] <= mem_data_in3;
    if (mem_Enable3 && mem_RE3) p0 <= mem3[mem_address3];
    p1 <= p0;
    p2 <= p1;
  end
  assign mem_data_out3 = p2;

  alu_mem_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b),
    .cmd_addr_z(cmd_addr_z), .done(done), .result(result), .op_count(op_count),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_WE(mem_WE),
    .mem_RE(mem_RE), .mem_Enable(mem_Enable), .mem_data_out(mem_data_out),
    .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_ctrl(alu_ctrl), .alu_aluout(alu_aluout)
  );

  alu_mem_sequencer #(.RD_LAT(3), .CNT_W(2)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op), .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b),
    .cmd_addr_z(cmd_addr_z), .done(done3), .result(result3), .op_count(op_count3),
    .mem_address(mem_address3), .mem_data_in(mem_data_in3), .mem_WE(mem_WE3),
    .mem_RE(mem_RE3), .mem_Enable(mem_Enable3), .mem_data_out(mem_data_out3),
    .alu_ain(alu_ain3), .alu_bin(alu_bin3), .alu_ctrl(alu_ctrl3), .alu_aluout(alu_aluout3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input bit use3, input logic [8:0] a, input logic [7:0] d);
    pre_sel  = use3;
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    wait_clk();
    pre_we   = 1'b0;
  endtask

  // Issue one command from IDLE, measure accept-to-done latency, check the
  // done pulse width and return to IDLE. Fields are scrambled after accept.
  task automatic run_cmd(input bit use3, input logic [3:0] op, input logic [8:0] a,
                         input logic [8:0] b, input logic [8:0] z, input int exp_lat);
    int lat;
    cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_addr_z = z;
    if (use3) cmd_valid3 = 1'b1; else cmd_valid = 1'b1;
    wait_clk();
    cmd_valid = 1'b0; cmd_valid3 = 1'b0;
    cmd_op = ~op; cmd_addr_a = ~a; cmd_addr_b = ~b; cmd_addr_z = ~z;
    lat = 1;
    while (!(use3 ? done3 : done) && lat < 40) begin
      wait_clk();
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(exp_lat));
    wait_clk();
    check_eq("done_pulse", 32'(use3 ? done3 : done), 32'd0);
    check_eq("ready_after", 32'(use3 ? cmd_ready3 : cmd_ready), 32'd1);
  endtask

  // Continuous protocol checks: WE/RE exclusive, Enable low in IDLE and DONE.
  always @(negedge clk) begin
    if (!reset) begin
      check_eq("we_re_excl", 32'(mem_WE & mem_RE), 32'd0);
      check_eq("we_re_excl3", 32'(mem_WE3 & mem_RE3), 32'd0);
      if (cmd_ready || done) check_eq("en_idle_done", 32'(mem_Enable), 32'd0);
      if (cmd_ready3 || done3) check_eq("en_idle_done3", 32'(mem_Enable3), 32'd0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"},  32'(cmd_ready), 32'd1);
    check_eq({tag, "_done"},   32'(done), 32'd0);
    check_eq({tag, "_result"}, 32'(result), 32'd0);
    check_eq({tag, "_count"},  32'(op_count), 32'd0);
    check_eq({tag, "_en"},     32'(mem_Enable), 32'd0);
    check_eq({tag, "_we"},     32'(mem_WE), 32'd0);
    check_eq({tag, "_re"},     32'(mem_RE), 32'd0);
    check_eq({tag, "_addr"},   32'(mem_address), 32'd0);
    check_eq({tag, "_ain"},    32'(alu_ain), 32'd0);
    check_eq({tag, "_ctrl"},   32'(alu_ctrl), 32'd0);
  endtask

  initial begin
    bit seen;
    int n;
    reset = 1'b1; cmd_valid = 1'b0; cmd_valid3 = 1'b0;
    pre_we = 1'b0; pre_sel = 1'b0; pre_addr = 9'd0; pre_data = 8'd0;
    cmd_op = 4'd0; cmd_addr_a = 9'd0; cmd_addr_b = 9'd0; cmd_addr_z = 9'd0;
    repeat (3) wait_clk();
    check_reset_outputs("rst");
    reset = 1'b0;

    // Basic add.
    preload(1'b0, 9'd5, 8'h3C);
    preload(1'b0, 9'd6, 8'h05);
    preload(1'b0, 9'd9, 8'h00);
    run_cmd(1'b0, 4'h0, 9'd5, 9'd6, 9'd9, 7);
    check_eq("basic_result", 32'(result), 32'h41);
    check_eq("basic_mem9", 32'(mem[9]), 32'h41);
    check_eq("basic_count", 32'(op_count), 32'd1);

    // Every opcode on A=8'hA6, B=8'h3B.
    preload(1'b0, 9'd1, 8'hA6);
    preload(1'b0, 9'd2, 8'h3B);
    for (int i = 0; i < 16; i++) begin
      run_cmd(1'b0, 4'(i), 9'd1, 9'd2, 9'd300, 7);
      check_eq("op_mem300", 32'(mem[300]), 32'(exp_tbl[i]));
      check_eq("op_result", 32'(result), 32'(exp_tbl[i]));
    end
    check_eq("ops_count", 32'(op_count), 32'd17);

    // Aliasing a == b == z.
    preload(1'b0, 9'd7, 8'h11);
    run_cmd(1'b0, 4'h0, 9'd7, 9'd7, 9'd7, 7);
    check_eq("alias_1", 32'(mem[7]), 32'h22);
    run_cmd(1'b0, 4'h0, 9'd7, 9'd7, 9'd7, 7);
    check_eq("alias_2", 32'(mem[7]), 32'h44);

    // Busy: valid held high, fields change every cycle; accepts at 0, 8, 16.
    preload(1'b0, 9'd204, 8'h5A);
    preload(1'b0, 9'd208, 8'h00);
    for (int i = 0; i < 17; i++) begin
      cmd_op = 4'(i); cmd_addr_a = 9'd1; cmd_addr_b = 9'd2; cmd_addr_z = 9'(200 + i);
      cmd_valid = 1'b1;
      wait_clk();
    end
    cmd_valid = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      wait_clk();
      n++;
    end
    check_eq("busy_done", 32'(done), 32'd1);
    wait_clk();
    check_eq("busy_mem200", 32'(mem[200]), 32'hE1);
    check_eq("busy_mem208", 32'(mem[208]), 32'hA7);
    check_eq("busy_mem216", 32'(mem[216]), 32'hE1);
    check_eq("busy_mem204", 32'(mem[204]), 32'h5A);
    check_eq("busy_count", 32'(op_count), 32'd22);

    // Reset during WAIT_B: no write, no done.
    preload(1'b0, 9'd50, 8'h77);
    cmd_op = 4'h0; cmd_addr_a = 9'd1; cmd_addr_b = 9'd2; cmd_addr_z = 9'd50;
    cmd_valid = 1'b1;
    wait_clk();
    cmd_valid = 1'b0;
    repeat (3) wait_clk();
    check_eq("waitb_en", 32'(mem_Enable), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_waitb");
    wait_clk();
    wait_clk();
    reset = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      wait_clk();
      if (done) seen = 1'b1;
    end
    check_eq("waitb_no_done", 32'(seen), 32'd0);
    check_eq("waitb_mem50", 32'(mem[50]), 32'h77);

    // Reset during WR_Z: WE dropped at once, target keeps its old value.
    preload(1'b0, 9'd51, 8'h66);
    cmd_op = 4'h0; cmd_addr_a = 9'd1; cmd_addr_b = 9'd2; cmd_addr_z = 9'd51;
    cmd_valid = 1'b1;
    wait_clk();
    cmd_valid = 1'b0;
    repeat (5) wait_clk();
    check_eq("wrz_we", 32'(mem_WE), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rst_wrz_we", 32'(mem_WE), 32'd0);
    check_eq("rst_wrz_en", 32'(mem_Enable), 32'd0);
    check_eq("rst_wrz_ready", 32'(cmd_ready), 32'd1);
    wait_clk();
    reset = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      wait_clk();
      if (done) seen = 1'b1;
    end
    check_eq("wrz_no_done", 32'(seen), 32'd0);
    check_eq("wrz_mem51", 32'(mem[51]), 32'h66);
    run_cmd(1'b0, 4'h0, 9'd5, 9'd6, 9'd9, 7);
    check_eq("post_rst_result", 32'(result), 32'h41);
    check_eq("post_rst_count", 32'(op_count), 32'd1);

    // RD_LAT=3 latency and 2-bit counter saturation.
    preload(1'b1, 9'd5, 8'h3C);
    preload(1'b1, 9'd6, 8'h05);
    run_cmd(1'b1, 4'h0, 9'd5, 9'd6, 9'd9, 11);
    check_eq("l3_result", 32'(result3), 32'h41);
    check_eq("l3_mem9", 32'(mem3[9]), 32'h41);
    check_eq("l3_count1", 32'(op_count3), 32'd1);
    run_cmd(1'b1, 4'h1, 9'd5, 9'd6, 9'd10, 11);
    check_eq("l3_mem10", 32'(mem3[10]), 32'h37);
    run_cmd(1'b1, 4'h2, 9'd5, 9'd6, 9'd11, 11);
    check_eq("l3_mem11", 32'(mem3[11]), 32'h04);
    check_eq("l3_count3", 32'(op_count3), 32'd3);
    run_cmd(1'b1, 4'hA, 9'd5, 9'd6, 9'd12, 11);
    run_cmd(1'b1, 4'hB, 9'd5, 9'd6, 9'd13, 11);
    check_eq("l3_mem13", 32'(mem3[13]), 32'h05);
    check_eq("l3_count_sat", 32'(op_count3), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
